// File: rtl/note_step_pkg.sv
// rtl/note_step_pkg.sv - shared constants, state encoding and top-octave step table
package note_step_pkg;

    localparam int FRAC_W  = 8;
    localparam int OCT_TOP = 10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PITCH  = 3'd1;
    localparam logic [2:0] ST_DIV    = 3'd2;
    localparam logic [2:0] ST_FETCH  = 3'd3;
    localparam logic [2:0] ST_INTERP = 3'd4;
    localparam logic [2:0] ST_SHIFT  = 3'd5;
    localparam logic [2:0] ST_OUT    = 3'd6;

    // Top-octave steps; entry 12 is exactly twice entry 0 so interpolation
    // from semitone 11 lands on the next octave's root.
    function automatic logic [23:0] base_step(input logic [3:0] k);
        case (k)
            4'd0:    base_step = 24'd3185014;
            4'd1:    base_step = 24'd3374405;
            4'd2:    base_step = 24'd3575058;
            4'd3:    base_step = 24'd3787642;
            4'd4:    base_step = 24'd4012866;
            4'd5:    base_step = 24'd4251484;
            4'd6:    base_step = 24'd4504291;
            4'd7:    base_step = 24'd4772129;
            4'd8:    base_step = 24'd5055895;
            4'd9:    base_step = 24'd5356534;
            4'd10:   base_step = 24'd5675050;
            4'd11:   base_step = 24'd6012506;
            4'd12:   base_step = 24'd6370028;
            default: base_step = 24'd0;
        endcase
    endfunction

endpackage

// File: rtl/note_step_engine_if.sv
// rtl/note_step_engine_if.sv - request/result handshake bundle for the step engine
interface note_step_engine_if #(
    parameter int PHASE_W = 24,
    parameter int BEND_W  = 14,
    parameter int VOICE_W = 3
);
    logic                      in_valid;
    logic                      in_ready;
    logic [6:0]                in_note;
    logic signed [BEND_W-1:0]  in_bend;
    logic [VOICE_W-1:0]        in_voice;
    logic                      out_valid;
    logic                      out_ready;
    logic [PHASE_W-1:0]        out_step;
    logic [VOICE_W-1:0]        out_voice;

    modport master (
        output in_valid, in_note, in_bend, in_voice, out_ready,
        input  in_ready, out_valid, out_step, out_voice
    );

    modport slave (
        input  in_valid, in_note, in_bend, in_voice, out_ready,
        output in_ready, out_valid, out_step, out_voice
    );
endinterface

// File: rtl/note_step_div12.sv
// rtl/note_step_div12.sv - iterative semitone to (octave, remainder) divider
module note_step_div12 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] semi,
    output logic [3:0] oct,
    output logic [3:0] rem_lo,
    output logic       done
);
    logic [6:0] rem;

    assign done   = (rem < 7'd12);
    assign rem_lo = rem[3:0];

    // Load on start, then peel off one octave per cycle until the remainder fits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= 7'd0;
            oct <= 4'd0;
        end else if (start) begin
            rem <= semi;
            oct <= 4'd0;
        end else if (!done) begin
            rem <= rem - 7'd12;
            oct <= oct + 4'd1;
        end
    end
endmodule

// File: rtl/note_step_engine.sv
// rtl/note_step_engine.sv - MIDI note plus bend to oscillator phase step
module note_step_engine
    import note_step_pkg::*;
#(
    parameter int PHASE_W    = 24,
    parameter int BEND_W     = 14,
    parameter int BEND_RANGE = 2,
    parameter int VOICE_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    note_step_engine_if.slave io
);
    localparam int PW = BEND_W + 6;
    localparam logic signed [PW-1:0] PITCH_MAX = PW'(127 * 256);

    logic [2:0]               state;
    logic [2:0]               state_nxt;
    logic                     div_start;
    logic                     div_done;
    logic [3:0]               oct;
    logic [3:0]               rem;
    logic [6:0]               note_q;
    logic signed [BEND_W-1:0] bend_q;
    logic [VOICE_W-1:0]       voice_q;
    logic [FRAC_W-1:0]        frac_q;
    logic [23:0]              a_q;
    logic [23:0]              b_q;
    logic [27:0]              v_q;
    logic signed [PW-1:0]     bend_scaled;
    logic signed [PW-1:0]     pitch_raw;
    logic [14:0]              pitch;

    // Pitch in 1/256 semitone from the captured request, clamped to the note range
    always_comb begin
        bend_scaled = ($signed({{6{bend_q[BEND_W-1]}}, bend_q}) * $signed(PW'(BEND_RANGE)))
                      >>> (BEND_W - 9);
        pitch_raw   = $signed(PW'({note_q, 8'd0})) + bend_scaled;
        if (pitch_raw[PW-1])
            pitch = 15'd0;
        else if (pitch_raw > PITCH_MAX)
            pitch = 15'd32512;
        else
            pitch = pitch_raw[14:0];
    end

    note_step_div12 u_div (
        .clk    (clk),
        .rst    (rst),
        .start  (div_start),
        .semi   (pitch[14:8]),
        .oct    (oct),
        .rem_lo (rem),
        .done   (div_done)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state sequencing; one request in flight at a time
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (io.in_valid) state_nxt = ST_PITCH;
            ST_PITCH:  state_nxt = ST_DIV;
            ST_DIV:    if (div_done) state_nxt = ST_FETCH;
            ST_FETCH:  state_nxt = ST_INTERP;
            ST_INTERP: state_nxt = ST_SHIFT;
            ST_SHIFT:  state_nxt = ST_OUT;
            ST_OUT:    if (io.out_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Handshake and divider control decoded from state
    always_comb begin
        io.in_ready  = (state == ST_IDLE);
        io.out_valid = (state == ST_OUT);
        div_start    = (state == ST_PITCH);
    end

    // Datapath registers: capture, fraction, table fetch, interpolation, octave shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            note_q       <= 7'd0;
            bend_q       <= '0;
            voice_q      <= '0;
            frac_q       <= '0;
            a_q          <= 24'd0;
            b_q          <= 24'd0;
            v_q          <= 28'd0;
            io.out_step  <= '0;
            io.out_voice <= '0;
        end else begin
            case (state)
                ST_IDLE: if (io.in_valid) begin
                    note_q  <= io.in_note;
                    bend_q  <= io.in_bend;
                    voice_q <= io.in_voice;
                end
                ST_PITCH: frac_q <= pitch[7:0];
                ST_FETCH: begin
                    a_q <= base_step(rem);
                    b_q <= base_step(rem + 4'd1);
                end
                ST_INTERP: v_q <= {4'd0, a_q}
                                  + ((({4'd0, b_q} - {4'd0, a_q}) * {20'd0, frac_q}) >> FRAC_W);
                ST_SHIFT: begin
                    io.out_step  <= PHASE_W'(v_q >> (4'(OCT_TOP) - oct)) << (PHASE_W - 24);
                    io.out_voice <= voice_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_note_step_engine.sv
// tb/tb_note_step_engine.sv - randomized and directed checks of note_step_engine
module tb_note_step_engine;
    localparam int PHASE_W    = 24;
    localparam int BEND_W     = 14;
    localparam int BEND_RANGE = 2;
    localparam int VOICE_W    = 3;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    int base_t [13] = '{3185014, 3374405, 3575058, 3787642, 4012866, 4251484, 4504291,
                        4772129, 5055895, 5356534, 5675050, 6012506, 6370028};

    note_step_engine_if #(.PHASE_W(PHASE_W), .BEND_W(BEND_W), .VOICE_W(VOICE_W)) bus ();

    note_step_engine #(
        .PHASE_W(PHASE_W), .BEND_W(BEND_W), .BEND_RANGE(BEND_RANGE), .VOICE_W(VOICE_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_pitch(input int note, input int bend);
        int scaled;
        int term;
        int p;
        int div;
        div    = 1 << (BEND_W - 9);
        scaled = bend * BEND_RANGE;
        term   = (scaled >= 0) ? scaled / div : -((-scaled + div - 1) / div);
        p      = note * 256 + term;
        if (p < 0) p = 0;
        if (p > 127 * 256) p = 127 * 256;
        return p;
    endfunction

    function automatic int model_oct(input int note, input int bend);
        return (model_pitch(note, bend) / 256) / 12;
    endfunction

    function automatic longint model_step(input int note, input int bend);
        int p;
        int semi;
        int frac;
        int oct;
        int rem;
        longint a;
        longint b;
        longint v;
        p    = model_pitch(note, bend);
        semi = p / 256;
        frac = p % 256;
        oct  = semi / 12;
        rem  = semi % 12;
        a    = base_t[rem];
        b    = base_t[rem + 1];
        v    = a + ((b - a) * frac) / 256;
        return (v / (longint'(1) << (10 - oct))) * (longint'(1) << (PHASE_W - 24));
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_req(input int note, input int bend, input int voice, input int hold,
                           output longint got);
        longint exp_step;
        int     exp_lat;
        int     lat;
        longint s0;
        exp_step = model_step(note, bend);
        exp_lat  = model_oct(note, bend) + 5;
        @(negedge clk);
        check("idle_ready", longint'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_note  = 7'(note);
        bus.in_bend  = 14'(bend);
        bus.in_voice = 3'(voice);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_note  = 7'($urandom);
        bus.in_bend  = 14'($urandom);
        bus.in_voice = 3'($urandom);
        check("busy_ready", longint'(bus.in_ready), 0);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        got = longint'(bus.out_step);
        check("step", got, exp_step);
        check("voice", longint'(bus.out_voice), voice);
        if (hold > 0) begin
            s0 = got;
            repeat (hold) begin
                @(posedge clk); #1;
            end
            check("hold_step", longint'(bus.out_step), s0);
            check("hold_voice", longint'(bus.out_voice), voice);
            check("hold_valid", longint'(bus.out_valid), 1);
            check("hold_ready", longint'(bus.in_ready), 0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("release_valid", longint'(bus.out_valid), 0);
        check("release_ready", longint'(bus.in_ready), 1);
    endtask

    initial begin
        longint got;
        longint prev;
        longint lo;
        longint hi;
        int     stray;
        n_cmp         = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_note   = 7'd0;
        bus.in_bend   = '0;
        bus.in_voice  = '0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_in_ready", longint'(bus.in_ready), 1);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_step", longint'(bus.out_step), 0);
        check("rst_out_voice", longint'(bus.out_voice), 0);
        @(negedge clk);
        rst = 1'b0;

        run_req(0, 0, 1, 0, got);
        check("note0", got, 3110);
        run_req(60, 0, 2, 0, got);
        check("note60", got, 99531);
        run_req(72, 0, 3, 0, got);
        check("note72", got, 199063);
        run_req(127, 0, 4, 0, got);
        check("note127", got, 4772129);

        run_req(69, 8191, 5, 0, got);
        lo = model_step(70, 0);
        hi = model_step(71, 0);
        check("bend_between", longint'(got >= lo && got <= hi), 1);

        run_req(127, 8191, 6, 0, got);
        check("clamp_hi", got, 4772129);
        run_req(0, -8192, 7, 0, got);
        check("clamp_lo", got, 3110);

        prev = 0;
        for (int b = -8192; b <= 8191; b += 1024) begin
            run_req(69, b, 0, 0, got);
            check("monotonic", longint'(got >= prev), 1);
            prev = got;
        end

        run_req(45, 1234, 5, 20, got);

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_note  = 7'd100;
        bus.in_bend  = '0;
        bus.in_voice = 3'd2;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", longint'(bus.in_ready), 1);
        check("mid_rst_valid", longint'(bus.out_valid), 0);
        check("mid_rst_step", longint'(bus.out_step), 0);
        check("mid_rst_voice", longint'(bus.out_voice), 0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) stray++;
        end
        check("no_result_after_rst", stray, 0);
        run_req(100, 0, 3, 0, got);

        for (int i = 0; i < 30; i++) begin
            run_req(int'($urandom_range(0, 127)), int'($urandom_range(0, 16383)) - 8192,
                    int'($urandom_range(0, 7)), 0, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
